tt_um_accelshark_psg_i2s_serializer: RTL

//  Downstream stage of the PSG voice mixer. Takes the signed 8-bit left/right mix sums
//  and emits a standard Philips I2S stream (MCLK, LRCK, SCLK, SDATA) to an external DAC.

---
 rtl/tt_um_accelshark_psg_i2s_serializer.sv | 87 ++++++++
 1 files changed

// File: rtl/tt_um_accelshark_psg_i2s_serializer.sv
// Philips I2S serializer for the PSG mixer: 8-bit L/R sums -> MCLK/LRCK/SCLK/SDATA, self-timed frame.
// Optional macro PSG_I2S_LSB_DITHER_EN fills the low slot byte from a 16-bit Galois LFSR.
module tt_um_accelshark_psg_i2s_serializer #(
  parameter int MCLK_DIV_LOG2 = 1,
  parameter int SCLK_DIV_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] mix_l,
  input  logic [7:0] mix_r,
  output logic       sample_strobe,
  output logic       mclk,
  output logic       lrck,
  output logic       sclk,
  output logic       sdata
);
  localparam int CW = SCLK_DIV_LOG2 + 5;

  logic [CW-1:0] r_cnt;
  logic [15:0]   r_word_l;
  logic [15:0]   r_word_r;
  logic          r_sdata;

  logic [4:0]    w_bit;
  logic [4:0]    w_idx;
  logic          w_frame_start;
  logic          w_bit_edge;
  logic [31:0]   w_frame;
  logic [7:0]    w_fill_l;
  logic [7:0]    w_fill_r;

  assign w_bit         = r_cnt[CW-1:SCLK_DIV_LOG2];
  assign w_frame_start = (r_cnt == '0);
  assign w_bit_edge    = (r_cnt[SCLK_DIV_LOG2-1:0] == '0);
  assign w_frame       = {r_word_l, r_word_r};
  // 32-b modulo 32: bit 0 wraps to F[0], the previous frame's R LSB (I2S one-bit delay)
  assign w_idx         = 5'd0 - w_bit;

`ifdef PSG_I2S_LSB_DITHER_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_shift;
  logic [15:0] w_lfsr_next;

  assign w_lfsr_shift = {1'b0, r_lfsr[15:1]};
  assign w_lfsr_next  = r_lfsr[0] ? (w_lfsr_shift ^ 16'hB400) : w_lfsr_shift;
  assign w_fill_l     = r_lfsr[7:0];
  assign w_fill_r     = r_lfsr[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (ena && w_frame_start) begin
      r_lfsr <= w_lfsr_next;
    end
  end
`else
  assign w_fill_l = 8'h00;
  assign w_fill_r = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_word_l <= 16'h0000;
      r_word_r <= 16'h0000;
      r_sdata  <= 1'b0;
    end else if (ena) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_frame_start) begin
        r_word_l <= {mix_l, w_fill_l};
        r_word_r <= {mix_r, w_fill_r};
      end
      // Reads the pre-latch hold regs at bit 0, so the old R LSB goes out first
      if (w_bit_edge) begin
        r_sdata <= w_frame[w_idx];
      end
    end
  end

  assign sample_strobe = w_frame_start & ena & ~rst;
  assign mclk          = r_cnt[MCLK_DIV_LOG2-1];
  assign sclk          = r_cnt[SCLK_DIV_LOG2-1];
  assign lrck          = r_cnt[CW-1];
  assign sdata         = r_sdata;

endmodule
